// File: rtl/hdlc_tx_framer_p.sv
// HDLC transmit framer: byte buffer, opening flag, zero-bit-stuffed payload and FCS,
// closing flag, and a 0x7F abort sequence. FCS is CRC-16-CCITT or CRC-32, both reflected.
module hdlc_tx_framer_p #(
  parameter int unsigned BUF_DEPTH = 128,
  parameter int unsigned FCS_WIDTH = 16,
  localparam int unsigned CNT_W = $clog2(BUF_DEPTH) + 1
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             TxEN,
  input  logic             Wr_Valid,
  input  logic [7:0]       Wr_Data,
  output logic             Wr_Ready,
  input  logic             Tx_Start,
  input  logic             Tx_AbortFrame,
  output logic             Tx,
  output logic             Tx_Busy,
  output logic             Tx_Done,
  output logic             Tx_Full,
  output logic             Tx_AbortedTrans,
  output logic [CNT_W-1:0] Tx_Count
);

  localparam int unsigned PTR_W = $clog2(BUF_DEPTH);
  localparam int unsigned BIT_W = 6;
  localparam logic [7:0] FLAG_BYTE  = 8'h7E;
  localparam logic [7:0] ABORT_BYTE = 8'h7F;
  localparam logic [31:0] POLY_32 = (FCS_WIDTH == 32) ? 32'hEDB8_8320 : 32'h0000_8408;
  localparam logic [FCS_WIDTH-1:0] POLY = POLY_32[FCS_WIDTH-1:0];
  localparam logic [BIT_W-1:0] FCS_LAST = BIT_W'(FCS_WIDTH - 1);
  localparam logic [BIT_W-1:0] FCS_END  = BIT_W'(FCS_WIDTH);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(BUF_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FLAG_O,
    S_DATA,
    S_FCS,
    S_FLAG_C,
    S_ABORT
  } state_t;

  state_t state_q, state_d;

  logic [7:0]           mem [BUF_DEPTH];
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]     count_d;
  logic [BIT_W-1:0]     bit_cnt_q, bit_cnt_d;
  logic [7:0]           byte_sr_q, byte_sr_d;
  logic [FCS_WIDTH-1:0] crc_q, crc_d;
  logic [FCS_WIDTH-1:0] fcs_sr_q, fcs_sr_d;
  logic [2:0]           ones_q, ones_d;
  logic                 tx_d, busy_d, done_d, full_d, ready_d, aborted_d;
  logic                 wr_fire, start_ok, abort_ok;

  // One reflected CRC step for a single payload bit.
  function automatic logic [FCS_WIDTH-1:0] crc_step(input logic [FCS_WIDTH-1:0] c,
                                                     input logic b);
    logic fb;
    fb = c[0] ^ b;
    crc_step = (c >> 1) ^ (fb ? POLY : '0);
  endfunction

  assign wr_fire  = Wr_Valid & Wr_Ready;
  assign start_ok = Tx_Start & ((Tx_Count != '0) | wr_fire);
  assign abort_ok = Tx_AbortFrame & (state_q != S_IDLE) & (state_q != S_ABORT);

  // State register.
  always_ff @(posedge Clk) begin
    if (Rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Next state, line bit, stuffing, CRC and buffer bookkeeping.
  always_comb begin
    state_d   = state_q;
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    count_d   = Tx_Count;
    bit_cnt_d = bit_cnt_q;
    byte_sr_d = byte_sr_q;
    crc_d     = crc_q;
    fcs_sr_d  = fcs_sr_q;
    ones_d    = ones_q;
    tx_d      = Tx;
    aborted_d = Tx_AbortedTrans;

    if (wr_fire) begin
      wr_ptr_d = wr_ptr_q + PTR_W'(1);
      count_d  = Tx_Count + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (TxEN) tx_d = 1'b1;
        if (start_ok) begin
          state_d   = S_FLAG_O;
          bit_cnt_d = '0;
          crc_d     = '1;
          ones_d    = '0;
          aborted_d = 1'b0;
        end
      end

      S_FLAG_O: begin
        if (TxEN) begin
          tx_d = FLAG_BYTE[bit_cnt_q[2:0]];
          if (bit_cnt_q[2:0] == 3'd7) begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
            byte_sr_d = mem[rd_ptr_q];
            rd_ptr_d  = rd_ptr_q + PTR_W'(1);
            count_d   = Tx_Count - CNT_W'(1);
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      S_DATA: begin
        if (TxEN) begin
          if (ones_q == 3'd5) begin
            tx_d   = 1'b0;
            ones_d = '0;
          end else begin
            tx_d      = byte_sr_q[0];
            byte_sr_d = {1'b0, byte_sr_q[7:1]};
            crc_d     = crc_step(crc_q, byte_sr_q[0]);
            ones_d    = byte_sr_q[0] ? ones_q + 3'd1 : 3'd0;
            if (bit_cnt_q[2:0] == 3'd7) begin
              bit_cnt_d = '0;
              if (Tx_Count != '0) begin
                byte_sr_d = mem[rd_ptr_q];
                rd_ptr_d  = rd_ptr_q + PTR_W'(1);
                count_d   = Tx_Count - CNT_W'(1);
              end else begin
                state_d  = S_FCS;
                fcs_sr_d = ~crc_d;
              end
            end else begin
              bit_cnt_d = bit_cnt_q + BIT_W'(1);
            end
          end
        end
      end

      S_FCS: begin
        if (TxEN) begin
          if (ones_q == 3'd5) begin
            // A stuffed zero may still be owed after the final FCS bit.
            tx_d   = 1'b0;
            ones_d = '0;
            if (bit_cnt_q == FCS_END) begin
              state_d   = S_FLAG_C;
              bit_cnt_d = '0;
            end
          end else begin
            tx_d      = fcs_sr_q[0];
            fcs_sr_d  = fcs_sr_q >> 1;
            ones_d    = fcs_sr_q[0] ? ones_q + 3'd1 : 3'd0;
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if ((bit_cnt_q == FCS_LAST) && !(fcs_sr_q[0] && (ones_q == 3'd4))) begin
              state_d   = S_FLAG_C;
              bit_cnt_d = '0;
            end
          end
        end
      end

      S_FLAG_C: begin
        if (TxEN) begin
          tx_d   = FLAG_BYTE[bit_cnt_q[2:0]];
          ones_d = '0;
          if (bit_cnt_q[2:0] == 3'd7) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      S_ABORT: begin
        if (TxEN) begin
          tx_d = ABORT_BYTE[bit_cnt_q[2:0]];
          if (bit_cnt_q[2:0] == 3'd7) begin
            state_d   = S_IDLE;
            bit_cnt_d = '0;
          end else begin
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
          end
        end
      end

      default: ;
    endcase

    // Abort wins over everything else; the bit already on the line completes first.
    if (abort_ok) begin
      state_d   = S_ABORT;
      count_d   = '0;
      rd_ptr_d  = wr_ptr_q;
      ones_d    = '0;
      aborted_d = 1'b1;
      byte_sr_d = byte_sr_q;
      crc_d     = crc_q;
      fcs_sr_d  = fcs_sr_q;
      if (TxEN) begin
        tx_d      = ABORT_BYTE[0];
        bit_cnt_d = BIT_W'(1);
      end else begin
        tx_d      = Tx;
        bit_cnt_d = '0;
      end
    end

    busy_d  = (state_d != S_IDLE);
    full_d  = (count_d == CNT_FULL);
    done_d  = (state_d == S_IDLE) && (count_d == '0);
    ready_d = !busy_d && !full_d;
  end

  // Datapath and registered status outputs.
  always_ff @(posedge Clk) begin
    if (Rst) begin
      wr_ptr_q        <= '0;
      rd_ptr_q        <= '0;
      bit_cnt_q       <= '0;
      byte_sr_q       <= '0;
      crc_q           <= '1;
      fcs_sr_q        <= '0;
      ones_q          <= '0;
      Tx              <= 1'b1;
      Tx_Busy         <= 1'b0;
      Tx_Done         <= 1'b1;
      Tx_Full         <= 1'b0;
      Tx_AbortedTrans <= 1'b0;
      Tx_Count        <= '0;
      Wr_Ready        <= 1'b1;
    end else begin
      wr_ptr_q        <= wr_ptr_d;
      rd_ptr_q        <= rd_ptr_d;
      bit_cnt_q       <= bit_cnt_d;
      byte_sr_q       <= byte_sr_d;
      crc_q           <= crc_d;
      fcs_sr_q        <= fcs_sr_d;
      ones_q          <= ones_d;
      Tx              <= tx_d;
      Tx_Busy         <= busy_d;
      Tx_Done         <= done_d;
      Tx_Full         <= full_d;
      Tx_AbortedTrans <= aborted_d;
      Tx_Count        <= count_d;
      Wr_Ready        <= ready_d;
    end
  end

  // Payload storage; emptiness is tracked by the pointers, so no reset is needed.
  always_ff @(posedge Clk) begin
    if (!Rst && wr_fire) mem[wr_ptr_q] <= Wr_Data;
  end

endmodule

// File: tb/tb_hdlc_tx_framer_p.sv
// Randomised bench for hdlc_tx_framer_p: two instances (CRC-16 and CRC-32) share stimulus;
// the captured line bits are compared with a frame built from the HDLC rules.
module tb_hdlc_tx_framer_p;

  localparam int unsigned DEPTH = 16;
  localparam int unsigned CW = $clog2(DEPTH) + 1;

  typedef bit bitq_t[$];
  typedef logic [7:0] byteq_t[$];

  logic clk = 1'b0;
  logic rst, txen, wr_valid, tx_start, tx_abort;
  logic [7:0] wr_data;
  logic tx_a, busy_a, done_a, full_a, abt_a, rdy_a;
  logic tx_b, busy_b, done_b, full_b, abt_b, rdy_b;
  logic [CW-1:0] cnt_a, cnt_b;

  always #5 clk = ~clk;

  hdlc_tx_framer_p #(.BUF_DEPTH(DEPTH), .FCS_WIDTH(16)) dut_a (
    .Clk(clk), .Rst(rst), .TxEN(txen), .Wr_Valid(wr_valid), .Wr_Data(wr_data),
    .Wr_Ready(rdy_a), .Tx_Start(tx_start), .Tx_AbortFrame(tx_abort), .Tx(tx_a),
    .Tx_Busy(busy_a), .Tx_Done(done_a), .Tx_Full(full_a), .Tx_AbortedTrans(abt_a),
    .Tx_Count(cnt_a));

  hdlc_tx_framer_p #(.BUF_DEPTH(DEPTH), .FCS_WIDTH(32)) dut_b (
    .Clk(clk), .Rst(rst), .TxEN(txen), .Wr_Valid(wr_valid), .Wr_Data(wr_data),
    .Wr_Ready(rdy_b), .Tx_Start(tx_start), .Tx_AbortFrame(tx_abort), .Tx(tx_b),
    .Tx_Busy(busy_b), .Tx_Done(done_b), .Tx_Full(full_b), .Tx_AbortedTrans(abt_b),
    .Tx_Count(cnt_b));

  int n_chk = 0;
  int n_pass = 0;
  int hold_err = 0;
  int en_mode = 0;
  int cyc = 0;
  int last_la, last_lb;
  bitq_t qa, qb, exp_a, exp_b;
  byteq_t pend;
  bit mdl_busy = 1'b0;
  logic en_s, pa_s, pb_s;

  logic [7:0] k16 [11] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                           8'h6E, 8'h90};
  logic [7:0] k32 [13] = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39,
                           8'h26, 8'h39, 8'hF4, 8'hCB};

  task automatic chk(input string tag, input longint got, input longint exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  // Bit-strobe pattern: 0 = continuous, 1 = one in four, 2 = random.
  always @(negedge clk) begin
    cyc = cyc + 1;
    case (en_mode)
      1:       txen = ((cyc % 4) == 0);
      2:       txen = 1'($urandom_range(0, 1));
      default: txen = 1'b1;
    endcase
  end

  // Line monitor: record one bit per strobe; the line must not move without a strobe.
  always @(posedge clk) begin
    en_s = txen;
    pa_s = tx_a;
    pb_s = tx_b;
    #1;
    if (!rst) begin
      if (en_s) begin
        qa.push_back(tx_a);
        qb.push_back(tx_b);
      end else if ((tx_a != pa_s) || (tx_b != pb_s)) begin
        hold_err++;
      end
    end
  end

  // Reference frame: flag, stuffed (payload + complemented CRC), flag.
  task automatic build(input byteq_t pl, input int fw, output bitq_t o);
    logic [31:0] crc, poly, mask;
    logic [7:0] f, v;
    bitq_t raw;
    int run;
    bit b;
    poly = (fw == 32) ? 32'hEDB88320 : 32'h00008408;
    mask = (fw == 32) ? 32'hFFFFFFFF : 32'h0000FFFF;
    crc = mask;
    f = 8'h7E;
    o.delete();
    for (int i = 0; i < 8; i++) o.push_back(f[i]);
    foreach (pl[k]) begin
      v = pl[k];
      for (int i = 0; i < 8; i++) begin
        b = v[i];
        raw.push_back(b);
        if (crc[0] ^ b) crc = (crc >> 1) ^ poly;
        else crc = crc >> 1;
      end
    end
    crc = ~crc & mask;
    for (int i = 0; i < fw; i++) raw.push_back(crc[i]);
    run = 0;
    foreach (raw[j]) begin
      o.push_back(raw[j]);
      run = raw[j] ? run + 1 : 0;
      if (run == 5) begin
        o.push_back(1'b0);
        run = 0;
      end
    end
    for (int i = 0; i < 8; i++) o.push_back(f[i]);
  endtask

  // Receiver view: strip flags, remove stuffed zeros, pack LSB-first bytes.
  task automatic destuff(input bitq_t s, input int len, output byteq_t o);
    bitq_t raw;
    int run;
    logic [7:0] v;
    run = 0;
    o.delete();
    for (int i = 8; i < len - 8; i++) begin
      if (run == 5) begin
        run = 0;
      end else begin
        raw.push_back(s[i]);
        run = s[i] ? run + 1 : 0;
      end
    end
    for (int i = 0; i + 7 < raw.size(); i += 8) begin
      for (int j = 0; j < 8; j++) v[j] = raw[i + j];
      o.push_back(v);
    end
  endtask

  function automatic int first_diff(input bitq_t got, input bitq_t exp);
    bit e;
    for (int i = 0; i < got.size(); i++) begin
      e = (i < exp.size()) ? exp[i] : 1'b1;
      if (got[i] != e) return i;
    end
    if (got.size() < exp.size()) return got.size();
    return -1;
  endfunction

  task automatic accept_start();
    if (!mdl_busy && pend.size() > 0) begin
      build(pend, 16, exp_a);
      build(pend, 32, exp_b);
      pend.delete();
      qa.delete();
      qb.delete();
      mdl_busy = 1'b1;
    end
  endtask

  task automatic push_byte(input logic [7:0] d, input bit st);
    @(negedge clk);
    wr_valid = 1'b1;
    wr_data  = d;
    tx_start = st;
    if (!mdl_busy && pend.size() < DEPTH) pend.push_back(d);
    @(posedge clk);
    #2;
    wr_valid = 1'b0;
    tx_start = 1'b0;
    if (st) accept_start();
  endtask

  task automatic start_only();
    @(negedge clk);
    tx_start = 1'b1;
    @(posedge clk);
    #2;
    tx_start = 1'b0;
    accept_start();
  endtask

  task automatic finish_frame(input string tag);
    int la, lb;
    la = -1;
    lb = -1;
    for (int i = 0; i < 4000; i++) begin
      if (la >= 0 && lb >= 0) break;
      @(posedge clk);
      #2;
      if (la < 0 && !busy_a) la = qa.size();
      if (lb < 0 && !busy_b) lb = qb.size();
    end
    chk({tag, "_busyfall_a"}, la, exp_a.size());
    chk({tag, "_busyfall_b"}, lb, exp_b.size());
    repeat (24) @(posedge clk);
    #2;
    chk({tag, "_bits_a"}, first_diff(qa, exp_a), -1);
    chk({tag, "_bits_b"}, first_diff(qb, exp_b), -1);
    chk({tag, "_done_a"}, done_a, 1);
    chk({tag, "_count_b"}, cnt_b, 0);
    last_la = la;
    last_lb = lb;
    mdl_busy = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst      = 1'b1;
    wr_valid = 1'b0;
    tx_start = 1'b0;
    tx_abort = 1'b0;
    wr_data  = 8'h00;
    @(posedge clk);
    #2;
    chk({tag, "_tx"}, tx_a, 1);
    chk({tag, "_busy"}, busy_a, 0);
    chk({tag, "_done"}, done_a, 1);
    chk({tag, "_full"}, full_a, 0);
    chk({tag, "_aborted"}, abt_a, 0);
    chk({tag, "_count"}, cnt_a, 0);
    chk({tag, "_ready"}, rdy_a, 1);
    chk({tag, "_tx_b"}, tx_b, 1);
    chk({tag, "_busy_b"}, busy_b, 0);
    @(negedge clk);
    rst = 1'b0;
    pend.delete();
    mdl_busy = 1'b0;
  endtask

  initial begin
    byteq_t rx;
    bitq_t t;
    logic [7:0] abyte;
    int na, nb, n;
    bit got_it;
    abyte = 8'h7F;
    txen = 1'b1;
    do_reset("rst0");

    // "123456789", start together with the last byte.
    for (int i = 0; i < 8; i++) push_byte(8'(8'h31 + i), 1'b0);
    chk("t1_count_pre", cnt_a, 8);
    push_byte(8'h39, 1'b1);
    chk("t1_busy_after_start", busy_a, 1);
    finish_frame("t1");
    destuff(qa, last_la, rx);
    chk("t1_rxlen_a", rx.size(), 11);
    for (int i = 0; i < 11; i++) chk($sformatf("t1_rx_a%0d", i), (i < rx.size()) ? rx[i] : -1, k16[i]);
    destuff(qb, last_lb, rx);
    chk("t1_rxlen_b", rx.size(), 13);
    for (int i = 0; i < 13; i++) chk($sformatf("t1_rx_b%0d", i), (i < rx.size()) ? rx[i] : -1, k32[i]);

    // All-ones payload exercises stuffing across byte and FCS boundaries.
    push_byte(8'hFF, 1'b0);
    push_byte(8'hFF, 1'b1);
    finish_frame("t3");
    destuff(qa, last_la, rx);
    chk("t3_rx0", (rx.size() > 0) ? rx[0] : -1, 8'hFF);
    chk("t3_rx1", (rx.size() > 1) ? rx[1] : -1, 8'hFF);

    // Fill the buffer, drop an extra write, then send and refill across the pointer wrap.
    for (int i = 0; i < DEPTH; i++) push_byte(8'($urandom), 1'b0);
    chk("t4_full", full_a, 1);
    chk("t4_ready", rdy_a, 0);
    chk("t4_done", done_a, 0);
    push_byte(8'hA5, 1'b0);
    chk("t4_count_drop", cnt_a, DEPTH);
    start_only();
    finish_frame("t4");
    for (int i = 0; i < 10; i++) push_byte(8'($urandom), i == 9);
    finish_frame("t4wrap");

    // Abort in the third payload byte.
    for (int i = 0; i < 8; i++) push_byte(8'(8'h11 * (i + 1)), i == 7);
    got_it = 1'b0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      if (qa.size() >= 8 + 16 + 3) begin
        got_it = 1'b1;
        break;
      end
    end
    chk("t5_reach_byte3", got_it, 1);
    na = qa.size();
    nb = qb.size();
    tx_abort = 1'b1;
    @(posedge clk);
    #2;
    tx_abort = 1'b0;
    chk("t5_count_flushed", cnt_a, 0);
    chk("t5_aborted_a", abt_a, 1);
    chk("t5_aborted_b", abt_b, 1);
    chk("t5_busy", busy_a, 1);
    t.delete();
    for (int i = 0; i < na; i++) t.push_back(exp_a[i]);
    for (int i = 0; i < 8; i++) t.push_back(abyte[i]);
    exp_a = t;
    t.delete();
    for (int i = 0; i < nb; i++) t.push_back(exp_b[i]);
    for (int i = 0; i < 8; i++) t.push_back(abyte[i]);
    exp_b = t;
    finish_frame("t5");
    chk("t5_aborted_sticky", abt_a, 1);
    push_byte(8'h42, 1'b1);
    chk("t5_aborted_cleared", abt_a, 0);
    finish_frame("t5next");

    // Sparse strobe, plus starts that must be ignored (closing flag, empty buffer).
    en_mode = 1;
    for (int i = 0; i < 9; i++) push_byte(8'(8'h31 + i), i == 8);
    got_it = 1'b0;
    for (int i = 0; i < 2000; i++) begin
      @(negedge clk);
      if (qa.size() >= exp_a.size() - 4) begin
        got_it = 1'b1;
        break;
      end
    end
    chk("t6_reach_flagc", got_it, 1);
    tx_start = 1'b1;
    @(posedge clk);
    #2;
    tx_start = 1'b0;
    finish_frame("t6");
    start_only();
    repeat (20) @(posedge clk);
    #2;
    chk("t6_empty_start_a", busy_a, 0);
    chk("t6_empty_start_b", busy_b, 0);

    // Random frames with random strobe.
    for (int f = 0; f < 6; f++) begin
      en_mode = (f % 2) ? 2 : 0;
      n = $urandom_range(1, DEPTH);
      for (int i = 0; i < n; i++)
        push_byte(($urandom_range(0, 2) == 0) ? 8'hFF : 8'($urandom), (f % 3 != 0) && (i == n - 1));
      chk($sformatf("r%0d_count", f), cnt_b, n);
      if (f % 3 == 0) start_only();
      finish_frame($sformatf("r%0d", f));
    end

    // Reset in the middle of a frame.
    en_mode = 0;
    for (int i = 0; i < 3; i++) push_byte(8'(8'hC3 + i), i == 2);
    repeat (20) @(posedge clk);
    #2;
    do_reset("rst_mid");

    chk("txen_hold", hold_err, 0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
